// File: rtl/ramb16_s2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ramb16_s2_pkg
//  Description : Shared types, geometry constants and lane-select helper for
//                the byte-wide front end of an 8K x 2 block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ramb16_s2_pkg;

  // Front-end sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RSP  = 2'd3
  } state_e;

  // Byte <-> RAM geometry
  localparam int BEATS      = 4;   // 2-bit beats per byte
  localparam int BEAT_W     = 2;   // RAM data width
  localparam int RAM_RD_LAT = 1;   // DO valid this many cycles after a read edge
  localparam int RAM_AW     = 13;  // RAM word address width
  localparam int BYTE_AW    = 11;  // byte address width

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Map a beat index to the bit-pair (lane) of the byte it carries.
  // Lane n covers byte bits [2n+1:2n].
  function automatic logic [BEAT_W-1:0] lane_sel(input logic [BEAT_W-1:0] beat,
                                                 input logic              msb_first);
    return msb_first ? (LAST_BEAT - beat) : beat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ramb16_s2_byte_gather.sv
`default_nettype none
// ============================================================================
//  Module      : ramb16_s2_byte_gather
//  Description : Collects 2-bit RAM read beats into one byte. Each captured
//                beat overwrites the lane selected by its beat index; the
//                merged byte (including the beat being captured this cycle)
//                is presented combinationally on byte_next.
//  Revision    : 1.0 - initial release
// ============================================================================
module ramb16_s2_byte_gather
  import ramb16_s2_pkg::*;
#(
  parameter string       LANE_ORDER = "LSB_FIRST",
  parameter logic [1:0]  SRVAL_OUT  = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [BEAT_W-1:0] cap_beat,
  input  logic [BEAT_W-1:0] din,
  output logic [7:0]        byte_next
);

  localparam bit MSB_FIRST = (LANE_ORDER == "MSB_FIRST");

  logic [7:0]        gathered;
  logic [BEAT_W-1:0] lane;

  // Merge the incoming beat into its lane without waiting for the register
  always_comb begin
    lane      = lane_sel(cap_beat, MSB_FIRST);
    byte_next = gathered;
    if (cap_en) begin
      byte_next[{lane, 1'b0} +: BEAT_W] = din;
    end
  end

  // Hold partially gathered byte; idles at what the RAM drives after SSR
  always_ff @(posedge clk) begin
    if (rst) begin
      gathered <= {BEATS{SRVAL_OUT}};
    end else if (cap_en) begin
      gathered <= byte_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ramb16_s2_byte_port.sv
`default_nettype none
// ============================================================================
//  Module      : ramb16_s2_byte_port
//  Description : Byte-wide valid/ready command/response front end for an
//                8K x 2 single-port block RAM. Each byte command becomes four
//                2-bit RAM beats at {byte_addr, beat}; read beats are gathered
//                back into a byte and returned on the response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ramb16_s2_byte_port
  import ramb16_s2_pkg::*;
#(
  parameter string      LANE_ORDER = "LSB_FIRST",
  parameter logic [1:0] SRVAL_OUT  = 2'b00
) (
  input  logic               clk,
  input  logic               rst,
  // command channel
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [BYTE_AW-1:0] cmd_addr,
  input  logic [7:0]         cmd_wdata,
  // response channel
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [7:0]         rsp_rdata,
  // RAM side
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [BEAT_W-1:0]  ram_di,
  output logic               ram_en,
  output logic               ram_we,
  output logic               ram_ssr,
  input  logic [BEAT_W-1:0]  ram_do
);

  localparam bit MSB_FIRST = (LANE_ORDER == "MSB_FIRST");

  state_e             state;
  logic [BEAT_W-1:0]  beat;
  logic [BEAT_W-1:0]  beat_nxt;
  logic [BYTE_AW-1:0] addr_q;
  logic [7:0]         wdata_q;

  // Read-capture tracking: one slot per cycle of RAM read latency
  logic               cap_v [RAM_RD_LAT];
  logic [BEAT_W-1:0]  cap_b [RAM_RD_LAT];
  logic               rd_issue;
  logic               last_cap;
  logic [7:0]         byte_next;

  // Bit pair of a byte carried by a given beat
  function automatic logic [BEAT_W-1:0] pick(input logic [7:0]        b,
                                             input logic [BEAT_W-1:0] bt);
    return b[{lane_sel(bt, MSB_FIRST), 1'b0} +: BEAT_W];
  endfunction

  assign beat_nxt = beat + 2'd1;
  assign rd_issue = ram_en & ~ram_we;
  assign last_cap = cap_v[RAM_RD_LAT-1] && (cap_b[RAM_RD_LAT-1] == LAST_BEAT);

  // SSR is never used: the gather path starts each byte from scratch
  assign ram_ssr = 1'b0;

  // Delay each issued read beat's index until its DO arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAM_RD_LAT; i++) begin
        cap_v[i] <= 1'b0;
        cap_b[i] <= '0;
      end
    end else begin
      cap_v[0] <= rd_issue;
      cap_b[0] <= ram_addr[BEAT_W-1:0];
      for (int i = 1; i < RAM_RD_LAT; i++) begin
        cap_v[i] <= cap_v[i-1];
        cap_b[i] <= cap_b[i-1];
      end
    end
  end

  ramb16_s2_byte_gather #(
    .LANE_ORDER (LANE_ORDER),
    .SRVAL_OUT  (SRVAL_OUT)
  ) u_gather (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (cap_v[RAM_RD_LAT-1]),
    .cap_beat  (cap_b[RAM_RD_LAT-1]),
    .din       (ram_do),
    .byte_next (byte_next)
  );

  // Command sequencing, beat generation and registered RAM/response drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_di    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // Latch the command; later input changes are ignored
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            beat      <= '0;
            cmd_ready <= 1'b0;
            ram_en    <= 1'b1;
            ram_we    <= cmd_we;
            ram_addr  <= {cmd_addr, 2'b00};
            ram_di    <= cmd_we ? pick(cmd_wdata, 2'b00) : 2'b00;
            state     <= cmd_we ? WR : RD;
          end
        end

        WR: begin
          if (beat == LAST_BEAT) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_di    <= '0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            beat     <= beat_nxt;
            ram_addr <= {addr_q, beat_nxt};
            ram_di   <= pick(wdata_q, beat_nxt);
          end
        end

        RD: begin
          // Issue side: stop enabling the RAM after the last beat
          if (ram_en) begin
            if (beat == LAST_BEAT) begin
              ram_en <= 1'b0;
            end else begin
              beat     <= beat_nxt;
              ram_addr <= {addr_q, beat_nxt};
            end
          end
          // Capture side: the byte is complete once the last beat lands
          if (last_cap) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= byte_next;
            state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ramb16_s2_byte_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ramb16_s2_byte_port
//  Description : Self-checking bench. Two front ends (LSB_FIRST, MSB_FIRST)
//                receive identical commands; each drives its own 8K x 2 RAM
//                model. A byte-level reference memory predicts RAM beats and
//                read responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ramb16_s2_byte_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cmd_valid;
  logic        cmd_we;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_ready;

  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic [7:0]  rsp_rdata [2];
  logic [12:0] ram_addr  [2];
  logic [1:0]  ram_di    [2];
  logic        ram_en    [2];
  logic        ram_we    [2];
  logic        ram_ssr   [2];

  // Byte-level reference contents as seen through each lane order
  logic [7:0]  ref_mem [2][2048];

  int checks = 0;
  int errors = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [1:0] mem [8192];
      logic [1:0] rdo;

      ramb16_s2_byte_port #(
        .LANE_ORDER (gi == 0 ? "LSB_FIRST" : "MSB_FIRST"),
        .SRVAL_OUT  (2'b00)
      ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready[gi]),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata[gi]),
        .ram_addr  (ram_addr[gi]),
        .ram_di    (ram_di[gi]),
        .ram_en    (ram_en[gi]),
        .ram_we    (ram_we[gi]),
        .ram_ssr   (ram_ssr[gi]),
        .ram_do    (rdo)
      );

      // RAM contents start at zero, with byte 0 preloaded to 0x3C
      initial begin
        logic [7:0] pre;
        pre = 8'h3C;
        rdo = '0;
        for (int j = 0; j < 8192; j++) mem[j] = '0;
        for (int k = 0; k < 4; k++) mem[k] = pre[2*(gi == 0 ? k : 3-k) +: 2];
      end

      // Single-port RAM, write-first not needed: DO updates only on reads
      always @(posedge clk) begin
        if (ram_en[gi]) begin
          if (ram_we[gi]) mem[ram_addr[gi]] <= ram_di[gi];
          else            rdo <= mem[ram_addr[gi]];
        end
      end
    end
  endgenerate

  // Byte lane carried by beat k for a given instance (0 = LSB_FIRST)
  function automatic int lane(input int inst, input int k);
    return (inst == 0) ? k : 3 - k;
  endfunction

  task automatic chk(input string tag, input int inst,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[inst %0d]: observed 0x%0h expected 0x%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_cmd_ready"}, i, cmd_ready[i], 1);
      chk({tag, "_rsp_valid"}, i, rsp_valid[i], 0);
      chk({tag, "_rsp_rdata"}, i, rsp_rdata[i], 0);
      chk({tag, "_ram_en"},    i, ram_en[i],    0);
      chk({tag, "_ram_we"},    i, ram_we[i],    0);
      chk({tag, "_ram_addr"},  i, ram_addr[i],  0);
      chk({tag, "_ram_di"},    i, ram_di[i],    0);
      chk({tag, "_ram_ssr"},   i, ram_ssr[i],   0);
    end
  endtask

  // Present one command at a negedge; returns at the negedge of cycle t+1
  task automatic send(input logic we, input logic [10:0] a, input logic [7:0] d);
    for (int i = 0; i < 2; i++) chk("accept_ready", i, cmd_ready[i], 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge clk);
    @(negedge clk);
    // Scramble fields after accept: they must have been latched
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = 11'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  // Write byte d at a; nb < 4 asserts reset after beat nb-1 has issued
  task automatic do_write(input logic [10:0] a, input logic [7:0] d, input int nb);
    send(1'b1, a, d);
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < 2; i++) begin
        chk("wr_en",   i, ram_en[i],    1);
        chk("wr_we",   i, ram_we[i],    1);
        chk("wr_addr", i, ram_addr[i],  {a, 2'(k)});
        chk("wr_di",   i, ram_di[i],    d[2*lane(i, k) +: 2]);
        chk("wr_busy", i, cmd_ready[i], 0);
      end
      if (nb < 4 && k == nb - 1) rst = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < nb; k++)
        ref_mem[i][a][2*lane(i, k) +: 2] = d[2*lane(i, k) +: 2];
    if (nb == 4) begin
      for (int i = 0; i < 2; i++) begin
        chk("wr_done_ready", i, cmd_ready[i], 1);
        chk("wr_done_en",    i, ram_en[i],    0);
        chk("wr_done_we",    i, ram_we[i],    0);
      end
    end else begin
      reset_check("abort");
      rst = 1'b0;
      repeat (3) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          chk("post_abort_en",    i, ram_en[i],    0);
          chk("post_abort_ready", i, cmd_ready[i], 1);
        end
      end
    end
  endtask

  // Read byte at a, holding rsp_ready low for 'stall' cycles of RSP_VALID
  task automatic do_read(input logic [10:0] a, input int stall);
    send(1'b0, a, 8'($urandom));
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) begin
        chk("rd_en",   i, ram_en[i],    1);
        chk("rd_we",   i, ram_we[i],    0);
        chk("rd_addr", i, ram_addr[i],  {a, 2'(k)});
        chk("rd_busy", i, cmd_ready[i], 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      chk("rd_gap_en",    i, ram_en[i],    0);
      chk("rd_gap_we",    i, ram_we[i],    0);
      chk("rd_gap_valid", i, rsp_valid[i], 0);
    end
    @(negedge clk);
    for (int s = 0; s < stall; s++) begin
      for (int i = 0; i < 2; i++) begin
        chk("stall_valid", i, rsp_valid[i], 1);
        chk("stall_rdata", i, rsp_rdata[i], ref_mem[i][a]);
        chk("stall_ready", i, cmd_ready[i], 0);
        chk("stall_en",    i, ram_en[i],    0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      chk("rsp_valid", i, rsp_valid[i], 1);
      chk("rsp_rdata", i, rsp_rdata[i], ref_mem[i][a]);
      chk("rsp_busy",  i, cmd_ready[i], 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("post_rsp_valid", i, rsp_valid[i], 0);
      chk("post_rsp_ready", i, cmd_ready[i], 1);
    end
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2048; j++) ref_mem[i][j] = 8'h00;
      ref_mem[i][0] = 8'h3C;
    end

    repeat (3) @(negedge clk);
    reset_check("reset");
    rst = 1'b0;
    @(negedge clk);
    reset_check("idle");

    // Basic write then read back, with and without response back-pressure
    do_write(11'h005, 8'hB4, 4);
    do_read (11'h005, 0);
    do_read (11'h005, 3);

    // Top-of-memory write, preloaded byte read
    do_write(11'h7FF, 8'hFF, 4);
    do_read (11'h000, 1);
    do_read (11'h7FF, 0);

    // Reset after two beats leaves a partial byte
    do_write(11'h010, 8'hFF, 2);
    do_read (11'h010, 0);

    // Overwrite byte 0 and read back
    do_write(11'h000, 8'hB4, 4);
    do_read (11'h000, 2);

    // Randomized traffic, biased towards the address extremes
    for (int n = 0; n < 24; n++) begin
      logic [10:0] a;
      int          sel;
      sel = int'($urandom_range(0, 3));
      a   = (sel == 0) ? 11'h000 : (sel == 1) ? 11'h7FF : 11'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), 4);
      else                           do_read(a, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
